imem_responder: RTL and testbench

Responder end of the fetch address interface: accepts the fetch PC each cycle and returns the addressed instruction word. At boot it runs a byte-serial program loader that fills instruction storage and holds the fetch stage until loading completes. It sits between the Fetch stage and the off-chip/testbench program source, and its hold output feeds the hazard logic that drives the PC register enable.

---
 rtl/imem_pkg.sv | 18 +
 rtl/word_packer.sv | 59 +++++
 rtl/imem_responder.sv | 105 ++++++++++
 tb/tb_imem_responder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory responder and its
// byte-serial program loader.
package imem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  localparam int IMEM_INSTR_WIDTH = 32;
  localparam int IMEM_BYTE_LANES  = IMEM_INSTR_WIDTH / 8;
  localparam logic [IMEM_INSTR_WIDTH-1:0] IMEM_NOP = '0;

  function automatic int byte_lanes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles program bytes little-endian into instruction words; emits a commit
// strobe with the finished (zero-filled on last) word in the accepting cycle.
module word_packer
  import imem_pkg::*;
#(
  parameter int LANES = IMEM_BYTE_LANES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 take,
  input  logic [7:0]           byte_in,
  input  logic                 last,
  output logic [LANES*8-1:0]   word,
  output logic                 commit
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [CNT_W-1:0]      lane_reg, lane_next;
  logic [LANES-1:0][7:0] part_reg, part_next;
  logic [LANES-1:0][7:0] word_lanes;
  logic                  at_top;

  assign at_top = (lane_reg == CNT_W'(LANES - 1));
  assign commit = take && (last || at_top);

  // Lanes below the counter come from the buffer, the current lane from the
  // incoming byte, and lanes above it are zero so a short final word is clean.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign word_lanes[gi] = (CNT_W'(gi) == lane_reg) ? byte_in :
                              (CNT_W'(gi) <  lane_reg) ? part_reg[gi] : 8'h00;
      assign part_next[gi]  = commit ? 8'h00 :
                              (take && (CNT_W'(gi) == lane_reg)) ? byte_in : part_reg[gi];
    end
  endgenerate

  always_comb begin
    lane_next = lane_reg;
    if (commit) begin
      lane_next = '0;
    end else if (take) begin
      lane_next = lane_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_reg <= '0;
      part_reg <= '0;
    end else begin
      lane_reg <= lane_next;
      part_reg <= part_next;
    end
  end

  assign word = word_lanes;

endmodule

// File: rtl/imem_responder.sv
// Instruction memory responder: boot-time byte loader fills storage while the
// fetch stage is held, then serves combinational fetches by PC.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = IMEM_INSTR_WIDTH,
  parameter int DEPTH       = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [7:0]             load_byte,
  input  logic                   load_last,
  output logic                   load_ready,
  input  logic [ADDR_WIDTH-1:0]  PCF,
  output logic [INSTR_WIDTH-1:0] InstrF,
  output logic                   holdF,
  output logic                   align_errF,
  output logic                   load_overflow
);

  localparam int LANES = byte_lanes(INSTR_WIDTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(IMEM_NOP);

  imem_state_t            state_reg, state_next;
  logic [PTR_W-1:0]       word_ptr_reg, word_ptr_next;
  logic                   overflow_reg, overflow_next;
  logic                   take;
  logic                   commit;
  logic                   at_end;
  logic [INSTR_WIDTH-1:0] packed_word;
  logic [PTR_W-1:0]       fetch_idx;
  logic [INSTR_WIDTH-1:0] storage [DEPTH];

  assign load_ready = (state_reg == LOAD);
  assign holdF      = (state_reg == LOAD);
  // A byte arriving during reset is dropped so reset never disturbs storage.
  assign take       = load_valid && load_ready && !reset;
  assign at_end     = (word_ptr_reg == PTR_W'(DEPTH - 1));

  word_packer #(
    .LANES(LANES)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .take   (take),
    .byte_in(load_byte),
    .last   (load_last),
    .word   (packed_word),
    .commit (commit)
  );

  always_comb begin
    state_next    = state_reg;
    word_ptr_next = word_ptr_reg;
    overflow_next = overflow_reg;
    case (state_reg)
      LOAD: begin
        if (commit) begin
          if (load_last) begin
            state_next = RUN;
          end else if (at_end) begin
            overflow_next = 1'b1;
            state_next    = RUN;
          end else begin
            word_ptr_next = word_ptr_reg + PTR_W'(1);
          end
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= LOAD;
      word_ptr_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_ptr_reg <= word_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage has no reset: a reload only overwrites the words it reaches.
  always_ff @(posedge clk) begin
    if (commit) begin
      storage[word_ptr_reg] <= packed_word;
    end
  end

  assign fetch_idx     = PTR_W'(32'(PCF[ADDR_WIDTH-1:2]) % DEPTH);
  assign InstrF        = (state_reg == RUN) ? storage[fetch_idx] : NOP;
  assign align_errF    = (state_reg == RUN) && (|PCF[1:0]);
  assign load_overflow = overflow_reg;

endmodule

// File: tb/tb_imem_responder.sv
// Randomized self-checking bench for imem_responder against a byte-list model
// of the loaded program image.
module tb_imem_responder;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic [7:0]  PCF;
  logic [31:0] InstrF;
  logic        holdF;
  logic        align_errF;
  logic        load_overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [64];
  bit          known     [64];
  logic [7:0]  prog_q [$];

  imem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .PCF          (PCF),
    .InstrF       (InstrF),
    .holdF        (holdF),
    .align_errF   (align_errF),
    .load_overflow(load_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected image: the first n bytes of the program, four per word, first byte lowest.
  function automatic void model_load(input logic [7:0] bq[$], input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = (k / 4) % 64;
      if (k % 4 == 0) mem_model[w] = 32'h0;
      known[w] = 1'b1;
      mem_model[w] = mem_model[w] | (32'(bq[k]) << (8 * (k % 4)));
    end
  endfunction

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", load_ready, 1);
    check("rst_hold", holdF, 1);
    check("rst_instr", InstrF, 32'h0);
    check("rst_align", align_errF, 0);
    check("rst_ovf", load_overflow, 0);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    #1;
    check("ready_on_byte", load_ready, 1);
    check("hold_before_edge", holdF, 1);
    check("nop_in_load", InstrF, 32'h0);
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_byte  = 8'($urandom);
    for (int g = 0; g < gap; g++) begin
      #1;
      check("ready_in_gap", load_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic load_program(input logic [7:0] bq[$], input int gmin, input int gmax);
    int n;
    n = bq.size();
    for (int i = 0; i < n; i++) begin
      send_byte(bq[i], (i == n - 1), (i == n - 1) ? 0 : int'($urandom_range(gmax, gmin)));
    end
    check("hold_after_last", holdF, 0);
    check("ready_after_last", load_ready, 0);
    model_load(bq, n);
    $display("load %0d bytes gap %0d..%0d done", n, gmin, gmax);
  endtask

  task automatic fetch(input logic [7:0] addr);
    int idx;
    PCF = addr;
    #1;
    idx = int'(addr >> 2);
    if (known[idx]) check("instr", InstrF, mem_model[idx]);
    check("align", align_errF, (addr[1:0] != 2'b00));
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0; PCF = 8'h00;
    for (int i = 0; i < 64; i++) begin
      known[i] = 1'b0;
      mem_model[i] = 32'h0;
    end
    @(posedge clk); #1;
    do_reset();
    PCF = 8'h01;
    #1;
    check("align_in_load", align_errF, 0);
    check("instr_in_load", InstrF, 32'h0);

    // Basic two-word program, back-to-back bytes.
    prog_q = '{8'h13, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h10, 8'h81, 8'hE2};
    load_program(prog_q, 0, 0);
    PCF = 8'h04; #1;
    check("t1_word1", InstrF, 32'hE2811001);
    PCF = 8'h00; #1;
    check("t1_word0", InstrF, 32'hE3A00013);
    $display("basic program fetch checked");

    // Same program with load_valid 1 on / 2 off.
    do_reset();
    load_program(prog_q, 2, 2);
    fetch(8'h00);
    fetch(8'h04);
    $display("gapped program fetch checked");

    // Short final word is zero-filled; misaligned fetch flags align_errF.
    do_reset();
    prog_q = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h11, 8'h22};
    load_program(prog_q, 0, 1);
    PCF = 8'h06; #1;
    check("t3_partial", InstrF, 32'h00002211);
    check("t3_align", align_errF, 1);
    $display("partial word fetch checked");

    // Overflow: 256 bytes fill every word; byte 257 must not be accepted.
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 257; i++) prog_q.push_back(8'($urandom));
    for (int i = 0; i < 256; i++) begin
      send_byte(prog_q[i], 1'b0, 0);
      if (i < 255) begin
        check("ovf_early", load_overflow, 0);
      end
    end
    check("ovf_set", load_overflow, 1);
    check("ovf_hold", holdF, 0);
    check("ovf_ready", load_ready, 0);
    model_load(prog_q, 256);
    load_valid = 1'b1; load_byte = prog_q[256];
    for (int c = 0; c < 3; c++) begin
      #1;
      check("ovf_257_ready", load_ready, 0);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    fetch(8'h00);
    fetch(8'hFC);
    fetch(8'h81);
    check("ovf_sticky", load_overflow, 1);
    $display("overflow load of 257 bytes checked");

    // Reset mid-load, then full reload.
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 5; i++) prog_q.push_back(8'($urandom));
    for (int i = 0; i < 5; i++) send_byte(prog_q[i], 1'b0, 0);
    model_load(prog_q, 4);
    do_reset();
    prog_q.delete();
    for (int i = 0; i < 8; i++) prog_q.push_back(8'($urandom));
    load_program(prog_q, 0, 1);
    fetch(8'h00);
    fetch(8'h04);
    check("reload_ovf", load_overflow, 0);
    $display("reset mid-load then reload checked");

    // In RUN the loader port is ignored.
    PCF = 8'h00;
    for (int c = 0; c < 24; c++) begin
      load_valid = 1'($urandom);
      load_byte  = 8'($urandom);
      load_last  = 1'($urandom);
      #1;
      check("run_ready", load_ready, 0);
      check("run_instr0", InstrF, mem_model[0]);
      @(posedge clk); #1;
    end
    load_valid = 1'b0; load_last = 1'b0;
    fetch(8'h04);
    $display("loader ignored in run checked");

    // Random programs and random fetches.
    for (int it = 0; it < 6; it++) begin
      int len;
      do_reset();
      len = int'($urandom_range(60, 1));
      prog_q.delete();
      for (int i = 0; i < len; i++) prog_q.push_back(8'($urandom));
      load_program(prog_q, 0, 2);
      for (int f = 0; f < 12; f++) begin
        int idx;
        idx = int'($urandom_range((len - 1) / 4, 0));
        fetch(8'(idx * 4 + int'($urandom_range(3, 0))));
      end
      $display("random program %0d len %0d fetches checked", it, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
